elastic_pipe_reg: RTL
=====================

# elastic_pipe_reg

Parametrised elastic pipeline register carrying a control/data bundle between two pipeline stages, such as decode to execute. It succeeds the fixed-field stage flop with four additions:
- a generic width;
- a valid/ready handshake, so stages can stall;
- an optional two-entry skid buffer, for full throughput with a registered `in_ready`;
- a synchronous flush that converts held entries into bubbles.

When nothing valid is presented, the output carries a programmable bubble value, so downstream stages never act on stale control bits.

## Interface
- `DATA_W`, default 20: width of the carried bundle in bits.
- `SKID`, default 1: selects the buffer mode.
  - 1: two-entry skid buffer, `in_ready` driven straight from a flop.
  - 0: single entry, `in_ready` combinational.
- `BUBBLE`, default 0 (`DATA_W` bits): value driven on `out_data` whenever `out_valid`=0.

Ports (reset is asynchronous, active-high; clock is `clk`):
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high; clears all entries.
- `flush` in 1: synchronous squash of all held entries and of the current input.
- `in_valid` in 1: upstream offers `in_data`.
- `in_ready` out 1: block can accept this cycle.
- `in_data` in `DATA_W`: bundle from the upstream stage.
- `out_valid` out 1: `out_data` holds a live entry.
- `out_ready` in 1: downstream consumes this cycle.
- `out_data` out `DATA_W`: bundle to the downstream stage; equals `BUBBLE` when `out_valid`=0.
- `squashed` out 1: registered pulse, 1 for the cycle after a flush that discarded at least one live entry or accepted input.

## Operation
- A transfer in happens when `in_valid & in_ready`. A transfer out happens when `out_valid & out_ready`.
- Entries leave in FIFO order. No entry is duplicated or lost except by flush.

SKID=1 state machine, with entries main (M) and skid (S):
- EMPTY:
  - on transfer in, load M and go to ONE.
- ONE:
  - in and out together: replace M, stay in ONE.
  - in only: write S, go to TWO.
  - out only: go to EMPTY.
- TWO (`in_ready`=0):
  - on out: S moves to M, go to ONE.
  - otherwise hold.
- `in_ready` = (state != TWO), taken from a flop.

SKID=0:
- Single entry M.
- `in_ready` = !`out_valid` | `out_ready`.
- Transfer in loads M. Out-without-in clears valid.

Flush:
- Flush has priority over every other event in that cycle.
- Next state is EMPTY, all valid bits clear, and M and S data are set to `BUBBLE`.
- Input presented in the flush cycle is dropped, even when `in_ready`=1.
- `squashed` is 1 next cycle if the block was non-empty, or if `in_valid`=1 in the flush cycle.

`out_data` is M when `out_valid`, else `BUBBLE`. This is a mux on the valid bit, so the data flops need no reset.

Reset (asynchronous) gives:
- state EMPTY;
- `out_valid`=0;
- `out_data`=`BUBBLE`;
- `in_ready`=1;
- `squashed`=0.

Reset may assert mid-operation. All entries are lost immediately, without waiting for a clock edge.

## Timing
- Latency is one cycle: data accepted at edge N appears on `out_data` after edge N.
- Throughput is one entry per cycle in both modes while `out_ready`=1.
- SKID=1:
  - `in_ready` falls the cycle after the second unconsumed accept.
  - Upstream may therefore push one more entry after `out_ready` drops, without loss.
- SKID=0: combinational path from `out_ready` to `in_ready`.
- `out_valid`, `out_data` and `squashed` are registered, or muxed only from registered state.
- Handshake rules:
  - Upstream holds `in_valid`/`in_data` stable until accepted, except when flush drops them.
  - The block holds `out_data` stable while `out_valid` & !`out_ready`.
- Simultaneous flush and `out_ready`: the head entry is counted as squashed and not consumed. Downstream ignores an `out_valid` whose cycle has `flush`=1.

## Test plan
- Reset applied with data 0xABCDE pending:
  - `out_valid`=0, `out_data`=`BUBBLE` (0), `in_ready`=1 immediately, without a clock edge.
- Stream 0x00001..0x00008 with `out_ready`=1, in both SKID modes:
  - outputs match in order, one per cycle, with one cycle of latency.
- SKID=1 backpressure:
  - push 0x11 and 0x22 with `out_ready`=0;
  - `in_ready`=0 after the second accept;
  - raise `out_ready`: outputs are 0x11 then 0x22, and `in_ready` returns to 1 after the first pop.
- Flush while in TWO with `in_valid`=1 (0x33):
  - next cycle `out_valid`=0, `out_data`=`BUBBLE`, `squashed`=1;
  - 0x33 never appears on the output.
- Flush while EMPTY with `in_valid`=0: `squashed`=0 and the state is unchanged.
- SKID=0, `out_ready`=0 with one entry held:
  - `in_ready`=0 combinationally;
  - raising `out_ready` while `in_valid` presents 0x44 produces a simultaneous pop and load, and 0x44 is output next cycle.

Source files
------------

// File: rtl/elastic_pipe_reg_if.sv
`default_nettype none
// ============================================================================
// Module      : elastic_pipe_reg_if
// Description : Handshake bundle for elastic_pipe_reg: upstream valid/ready/data,
//               downstream valid/ready/data, flush request and squash report.
// Revision    : 1.0 - initial release
// ============================================================================
interface elastic_pipe_reg_if #(
    parameter int DATA_W = 20
);
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              squashed;

    // master drives the register (both neighbouring stages), slave is the register
    modport master (
        output flush, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, squashed
    );

    modport slave (
        input  flush, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, squashed
    );
endinterface
`default_nettype wire

// File: rtl/elastic_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module      : elastic_pipe_reg
// Description : Elastic pipeline register with valid/ready handshake, optional
//               two-entry skid buffer, synchronous flush and bubble insertion.
// Revision    : 1.0 - initial release
// ============================================================================
module elastic_pipe_reg #(
    parameter int                DATA_W = 20,
    parameter int                SKID   = 1,
    parameter logic [DATA_W-1:0] BUBBLE = '0
) (
    input  wire logic           clk,
    input  wire logic           reset,
    elastic_pipe_reg_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    generate
        if (SKID != 0) begin : g_skid
            state_t            r_state;
            state_t            w_nextState;
            logic [DATA_W-1:0] r_main;
            logic [DATA_W-1:0] r_skid;
            logic              r_inReady;
            logic              r_squashed;
            logic              w_outValid;
            logic              w_inXfer;
            logic              w_outXfer;
            logic              w_loadMainIn;
            logic              w_loadMainSkid;
            logic              w_loadSkid;

            assign w_outValid = (r_state != ST_EMPTY);
            assign w_inXfer   = bus.in_valid & r_inReady;
            assign w_outXfer  = w_outValid & bus.out_ready;

            always_comb begin
                w_nextState    = r_state;
                w_loadMainIn   = 1'b0;
                w_loadMainSkid = 1'b0;
                w_loadSkid     = 1'b0;
                if (bus.flush) begin
                    w_nextState = ST_EMPTY;
                end else begin
                    case (r_state)
                        ST_EMPTY: begin
                            if (w_inXfer) begin
                                w_loadMainIn = 1'b1;
                                w_nextState  = ST_ONE;
                            end
                        end
                        ST_ONE: begin
                            if (w_inXfer && w_outXfer) begin
                                w_loadMainIn = 1'b1;
                            end else if (w_inXfer) begin
                                w_loadSkid  = 1'b1;
                                w_nextState = ST_TWO;
                            end else if (w_outXfer) begin
                                w_nextState = ST_EMPTY;
                            end
                        end
                        ST_TWO: begin
                            if (w_outXfer) begin
                                w_loadMainSkid = 1'b1;
                                w_nextState    = ST_ONE;
                            end
                        end
                        default: w_nextState = ST_EMPTY;
                    endcase
                end
            end

            // in_ready is precomputed from the next state so it leaves a flop directly
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_state    <= ST_EMPTY;
                    r_inReady  <= 1'b1;
                    r_squashed <= 1'b0;
                end else begin
                    r_state    <= w_nextState;
                    r_inReady  <= (w_nextState != ST_TWO);
                    r_squashed <= bus.flush & (w_outValid | bus.in_valid);
                end
            end

            always_ff @(posedge clk) begin
                if (bus.flush) begin
                    r_main <= BUBBLE;
                    r_skid <= BUBBLE;
                end else begin
                    if (w_loadMainIn) begin
                        r_main <= bus.in_data;
                    end else if (w_loadMainSkid) begin
                        r_main <= r_skid;
                    end
                    if (w_loadSkid) begin
                        r_skid <= bus.in_data;
                    end
                end
            end

            assign bus.in_ready  = r_inReady;
            assign bus.out_valid = w_outValid;
            assign bus.out_data  = w_outValid ? r_main : BUBBLE;
            assign bus.squashed  = r_squashed;
        end else begin : g_single
            logic [DATA_W-1:0] r_main;
            logic              r_valid;
            logic              r_squashed;
            logic              w_inReady;
            logic              w_inXfer;
            logic              w_outXfer;

            assign w_inReady = ~r_valid | bus.out_ready;
            assign w_inXfer  = bus.in_valid & w_inReady;
            assign w_outXfer = r_valid & bus.out_ready;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_valid    <= 1'b0;
                    r_squashed <= 1'b0;
                end else begin
                    r_squashed <= bus.flush & (r_valid | bus.in_valid);
                    if (bus.flush) begin
                        r_valid <= 1'b0;
                    end else if (w_inXfer) begin
                        r_valid <= 1'b1;
                    end else if (w_outXfer) begin
                        r_valid <= 1'b0;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (bus.flush) begin
                    r_main <= BUBBLE;
                end else if (w_inXfer) begin
                    r_main <= bus.in_data;
                end
            end

            assign bus.in_ready  = w_inReady;
            assign bus.out_valid = r_valid;
            assign bus.out_data  = r_valid ? r_main : BUBBLE;
            assign bus.squashed  = r_squashed;
        end
    endgenerate

endmodule
`default_nettype wire
